// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock timekeeping core.
// Holds the mode encoding, the digit limits and the mode-sequencing helper.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_TENS_MAX = 5;
  localparam int HR_MAX       = 23;

  localparam int SEC_MOD = (SEC_TENS_MAX + 1) * 10;
  localparam int MIN_MOD = (MIN_TENS_MAX + 1) * 10;
  localparam int HR_MOD  = HR_MAX + 1;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    unique case (m)
      RUN:     n = SET_HR;
      SET_HR:  n = SET_MIN;
      default: n = RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MOD-1 back to 00.
// Ports: clk, reset_n (sync, active-low), inc, clear -> ones, tens, carry (inc at wrap).
import clock_pkg::*;

module bcd_mod_counter #(
  parameter int MOD = SEC_MOD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry
);

  localparam logic [3:0] ONES_MAX = 4'((MOD - 1) % 10);
  localparam logic [3:0] TENS_MAX = 4'((MOD - 1) / 10);

  logic at_max;

  assign at_max = (ones == ONES_MAX) && (tens == TENS_MAX);

  // Combinational so the next field steps on the same edge.
  assign carry = inc && at_max && !clear;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ones <= '0;
      tens <= '0;
    end else if (clear) begin
      ones <= '0;
      tens <= '0;
    end else if (inc) begin
      if (at_max) begin
        ones <= '0;
        tens <= '0;
      end else if (ones == 4'd9) begin
        ones <= '0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS BCD timekeeper with 1 Hz prescaler, button set mode and blink flags.
// Ports: clk, reset_n, mode_btn, inc_btn -> six BCD digits, mode, blank_hr/min, tick_1hz.
import clock_pkg::*;

module bcd_time_counter #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       tick_1hz
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

  mode_t         mode_q;
  logic [PW-1:0] pre_q;
  logic [BW-1:0] blk_q;
  logic          phase_q;

  logic run;
  logic tick;
  logic set_inc;
  logic leave_set;
  logic sec_c;
  logic min_c;
  logic hr_carry_unused;

  assign run = (mode_q == RUN);

  // A mode press on the wrap cycle wins: time freezes, no tick.
  assign tick      = run && !mode_btn && (pre_q == PRE_MAX);
  assign set_inc   = inc_btn && !mode_btn;
  assign leave_set = mode_btn && (mode_q == SET_MIN);

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (tick),
    .clear   (leave_set),
    .ones    (sec_ones),
    .tens    (sec_tens),
    .carry   (sec_c)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (sec_c || (set_inc && mode_q == SET_MIN)),
    .clear   (1'b0),
    .ones    (min_ones),
    .tens    (min_tens),
    .carry   (min_c)
  );

  // Minute wraps while setting must not carry into hours.
  bcd_mod_counter #(.MOD(HR_MOD)) u_hr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     ((min_c && run) || (set_inc && mode_q == SET_HR)),
    .clear   (1'b0),
    .ones    (hr_ones),
    .tens    (hr_tens),
    .carry   (hr_carry_unused)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q   <= RUN;
      pre_q    <= '0;
      blk_q    <= '0;
      phase_q  <= 1'b0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= tick;
      if (mode_btn) begin
        mode_q  <= next_mode(mode_q);
        pre_q   <= '0;
        blk_q   <= '0;
        phase_q <= 1'b0;
      end else if (run) begin
        pre_q <= tick ? '0 : pre_q + PW'(1);
      end else if (blk_q == BLK_MAX) begin
        blk_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        blk_q <= blk_q + BW'(1);
      end
    end
  end

  assign mode      = mode_q;
  assign blank_hr  = (mode_q == SET_HR) && phase_q;
  assign blank_min = (mode_q == SET_MIN) && phase_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter (CLK_HZ=4, BLINK_DIV=2).
// Vector table, directed corner sequences and a random run against a seconds-of-day model.
module tb_bcd_time_counter;

  localparam int CLK_HZ    = 4;
  localparam int BLINK_DIV = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic [1:0] mode;
  logic       blank_hr, blank_min, tick_1hz;

  int total = 0;
  int bad = 0;

  int m_t = 0;
  int m_mode = 0;
  int m_pc = 0;
  int m_bc = 0;
  int m_ph = 0;
  int m_tick = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(
    .CLK_HZ    (CLK_HZ),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .hr_ones   (hr_ones),
    .hr_tens   (hr_tens),
    .mode      (mode),
    .blank_hr  (blank_hr),
    .blank_min (blank_min),
    .tick_1hz  (tick_1hz)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int dut_h();
    return int'(hr_tens) * 10 + int'(hr_ones);
  endfunction

  function automatic int dut_m();
    return int'(min_tens) * 10 + int'(min_ones);
  endfunction

  function automatic int dut_s();
    return int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  function automatic logic [31:0] dut_state();
    return {3'b0, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
            mode, tick_1hz, blank_hr, blank_min};
  endfunction

  // Expected outputs from the model: time kept as seconds since midnight.
  function automatic logic [31:0] exp_state();
    int h, mi, s;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    return {3'b0, 4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10),
            4'(s / 10), 4'(s % 10), 2'(m_mode), 1'(m_tick),
            1'(m_mode == 1 && m_ph == 1), 1'(m_mode == 2 && m_ph == 1)};
  endfunction

  task automatic model_step(input bit mb, input bit ib, input bit rn);
    int h, mi, s;
    if (!rn) begin
      m_t = 0; m_mode = 0; m_pc = 0; m_bc = 0; m_ph = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (mb) begin
        if (m_mode == 2) m_t = m_t - (m_t % 60);
        m_mode = (m_mode + 1) % 3;
        m_pc = 0; m_bc = 0; m_ph = 0;
      end else if (m_mode == 0) begin
        if (m_pc == CLK_HZ - 1) begin
          m_pc = 0;
          m_t = (m_t + 1) % 86400;
          m_tick = 1;
        end else begin
          m_pc++;
        end
      end else begin
        if (ib) begin
          h  = m_t / 3600;
          mi = (m_t / 60) % 60;
          s  = m_t % 60;
          if (m_mode == 1) h = (h + 1) % 24;
          else mi = (mi + 1) % 60;
          m_t = h * 3600 + mi * 60 + s;
        end
        if (m_bc == BLINK_DIV - 1) begin
          m_bc = 0;
          m_ph = 1 - m_ph;
        end else begin
          m_bc++;
        end
      end
    end
  endtask

  task automatic cyc(input bit mb, input bit ib, input bit rn);
    mode_btn = mb;
    inc_btn  = ib;
    reset_n  = rn;
    @(posedge clk);
    model_step(mb, ib, rn);
    #1;
    chk("state", dut_state(), exp_state());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1);
  endtask

  typedef struct {
    bit mb;
    bit ib;
    bit rn;
    int h;
    int m;
    int md;
    bit bh;
    bit bm;
  } vec_t;

  vec_t tv[13];
  bit   bl[8];
  int   ticks;

  initial begin
    tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 1, 0, 0, 1, 0, 0};
    tv[2]  = '{0, 1, 1, 1, 0, 1, 0, 0};
    tv[3]  = '{0, 1, 1, 2, 0, 1, 1, 0};
    tv[4]  = '{0, 0, 1, 2, 0, 1, 1, 0};
    tv[5]  = '{0, 0, 1, 2, 0, 1, 0, 0};
    tv[6]  = '{1, 0, 1, 2, 0, 2, 0, 0};
    tv[7]  = '{1, 1, 1, 2, 0, 0, 0, 0};
    tv[8]  = '{1, 0, 1, 2, 0, 1, 0, 0};
    tv[9]  = '{1, 0, 1, 2, 0, 2, 0, 0};
    tv[10] = '{0, 1, 1, 2, 1, 2, 0, 0};
    tv[11] = '{0, 1, 1, 2, 2, 2, 0, 1};
    tv[12] = '{0, 0, 0, 0, 0, 0, 0, 0};

    // Reset for two cycles, then the first tick lands on the 4th cycle.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_digits", {8'b0, hr_tens, hr_ones, min_tens, min_ones,
                       sec_tens, sec_ones}, 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_blank", {30'b0, blank_hr, blank_min}, 32'd0);
    chk("rst_tick", 32'(tick_1hz), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk($sformatf("first_tick_c%0d", i), 32'(tick_1hz), 32'(i == 4));
    end
    chk("first_sec", 32'(dut_s()), 32'd1);

    // Table of short button sequences with hand-derived outputs.
    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].mb, tv[i].ib, tv[i].rn);
      chk($sformatf("vec%0d_h", i), 32'(dut_h()), 32'(tv[i].h));
      chk($sformatf("vec%0d_m", i), 32'(dut_m()), 32'(tv[i].m));
      chk($sformatf("vec%0d_mode", i), 32'(mode), 32'(tv[i].md));
      chk($sformatf("vec%0d_bh", i), 32'(blank_hr), 32'(tv[i].bh));
      chk($sformatf("vec%0d_bm", i), 32'(blank_min), 32'(tv[i].bm));
    end

    // Hour set wrap.
    cyc(1'b1, 1'b0, 1'b1);
    incs(5);
    chk("hr_set5", 32'(dut_h()), 32'd5);
    incs(24);
    chk("hr_wrap24", 32'(dut_h()), 32'd5);
    incs(18);
    chk("hr_set23", 32'(dut_h()), 32'd23);
    incs(1);
    chk("hr_23to0", 32'(dut_h()), 32'd0);
    chk("hr_min_kept", 32'(dut_m()), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      bl[i] = blank_hr;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("blink_toggle%0d", i), 32'(bl[i] ^ bl[i+2]), 32'd1);

    // Minute set wrap at 12:59.
    incs(12);
    cyc(1'b1, 1'b0, 1'b1);
    incs(59);
    chk("min_set59", 32'(dut_m()), 32'd59);
    incs(1);
    chk("min_59to0", 32'(dut_m()), 32'd0);
    chk("min_no_carry", 32'(dut_h()), 32'd12);
    cyc(1'b1, 1'b0, 1'b1);
    chk("run_mode", 32'(mode), 32'd0);
    chk("run_sec0", 32'(dut_s()), 32'd0);

    // Leaving set mode clears running seconds and restarts the prescaler.
    idle(13);
    chk("sec_running", 32'(dut_s()), 32'd3);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("sec_cleared", 32'(dut_s()), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk($sformatf("restart_tick_c%0d", i), 32'(tick_1hz), 32'(i == 4));
    end

    // Simultaneous buttons in SET_HR at 07.
    cyc(1'b1, 1'b0, 1'b1);
    incs(19);
    chk("simul_h7", 32'(dut_h()), 32'd7);
    cyc(1'b1, 1'b1, 1'b1);
    chk("simul_mode", 32'(mode), 32'd2);
    chk("simul_hold", 32'(dut_h()), 32'd7);

    // Reset in SET_MIN at 10:34.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    incs(3);
    cyc(1'b1, 1'b0, 1'b1);
    incs(34);
    chk("preset_1034", 32'(dut_h() * 100 + dut_m()), 32'd1034);
    cyc(1'b0, 1'b0, 1'b0);
    chk("midset_rst", {6'b0, hr_tens, hr_ones, min_tens, min_ones,
                       sec_tens, sec_ones, mode}, 32'd0);
    chk("midset_blank", {30'b0, blank_hr, blank_min}, 32'd0);

    // Preset 23:59:00, run to 23:59:58, then cross midnight.
    cyc(1'b1, 1'b0, 1'b1);
    incs(23);
    cyc(1'b1, 1'b0, 1'b1);
    incs(59);
    cyc(1'b1, 1'b0, 1'b1);
    idle(58 * CLK_HZ);
    chk("roll_235958", 32'(dut_h() * 10000 + dut_m() * 100 + dut_s()),
        32'd235958);
    ticks = 0;
    for (int i = 0; i < CLK_HZ; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      ticks += int'(tick_1hz);
    end
    chk("roll_235959", 32'(dut_h() * 10000 + dut_m() * 100 + dut_s()),
        32'd235959);
    chk("roll_ticks1", 32'(ticks), 32'd1);
    ticks = 0;
    for (int i = 0; i < CLK_HZ; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      ticks += int'(tick_1hz);
    end
    chk("roll_000000", {8'b0, hr_tens, hr_ones, min_tens, min_ones,
                        sec_tens, sec_ones}, 32'd0);
    chk("roll_ticks2", 32'(ticks), 32'd1);

    // Random buttons and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 499) != 0);
      chk("rand_legal", 32'(hr_tens <= 4'd2 && dut_h() <= 23 &&
                            hr_ones <= 4'd9 && min_tens <= 4'd5 &&
                            min_ones <= 4'd9 && sec_tens <= 4'd5 &&
                            sec_ones <= 4'd9), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
